// File: rtl/exe_lsu_if.sv
// rtl/exe_lsu_if.sv - pipeline-side and data-memory-side bundles for exe_lsu
interface exe_lsu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [4:0]      in_rd;
    logic            in_flush;
    logic            out_valid;
    logic            out_wen;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data;
    logic [1:0]      out_err;

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd, in_flush,
        input  in_ready, out_valid, out_wen, out_rd, out_data, out_err
    );
    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd, in_flush,
        output in_ready, out_valid, out_wen, out_rd, out_data, out_err
    );
endinterface

interface exe_lsu_mem_if #(
    parameter int XLEN = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/exe_lsu.sv
// rtl/exe_lsu.sv - single-outstanding load/store unit with lane alignment, timeout and flush
module exe_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    exe_lsu_if.slave       alu_io,
    exe_lsu_mem_if.master  mem_io
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [1:0]        err_q, err_d;
    logic [XLEN-1:0]   maddr_q, maddr_d;
    logic [NB-1:0]     be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;

    logic              st_w;
    logic [2:0]        f3_w;
    logic [OFFW-1:0]   off_w;
    logic              illegal_w;
    logic              misal_w;
    logic [NB-1:0]     be_w;
    logic [XLEN-1:0]   wdata_sh_w;
    logic [XLEN-1:0]   addr_al_w;
    logic [XLEN-1:0]   rsh_w;
    logic [XLEN-1:0]   ext_w;
    logic [CW-1:0]     cnt_inc_w;

    // Decode of the offered operation; only meaningful while IDLE
    always_comb begin
        st_w       = alu_io.in_op[3];
        f3_w       = alu_io.in_op[2:0];
        off_w      = alu_io.in_addr[OFFW-1:0];
        illegal_w  = (f3_w == 3'b111) || (st_w && f3_w[2]) ||
                     ((XLEN == 32) && ((f3_w == 3'b011) || (f3_w == 3'b110)));
        case (f3_w[1:0])
            2'b00:   misal_w = 1'b0;
            2'b01:   misal_w = alu_io.in_addr[0];
            2'b10:   misal_w = |alu_io.in_addr[1:0];
            default: misal_w = |alu_io.in_addr[2:0];
        endcase
        be_w = '0;
        for (int i = 0; i < NB; i++) begin
            be_w[i] = (i >= int'(off_w)) && (i < int'(off_w) + (1 << f3_w[1:0]));
        end
        wdata_sh_w = alu_io.in_wdata << {off_w, 3'b000};
        addr_al_w  = {alu_io.in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    end

    always_comb begin
        rsh_w = mem_io.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext_w = XLEN'($signed(rsh_w[7:0]));
            3'b100:  ext_w = XLEN'(rsh_w[7:0]);
            3'b001:  ext_w = XLEN'($signed(rsh_w[15:0]));
            3'b101:  ext_w = XLEN'(rsh_w[15:0]);
            3'b010:  ext_w = XLEN'($signed(rsh_w[31:0]));
            3'b110:  ext_w = XLEN'(rsh_w[31:0]);
            default: ext_w = rsh_w;
        endcase
        cnt_inc_w = cnt_q + CW'(1);
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        data_d  = data_q;
        err_d   = err_q;
        maddr_d = maddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (alu_io.in_valid && !alu_io.in_flush) begin
                    store_d = st_w;
                    f3_d    = f3_w;
                    off_d   = off_w;
                    rd_d    = alu_io.in_rd;
                    data_d  = '0;
                    cnt_d   = '0;
                    kill_d  = 1'b0;
                    if (illegal_w) begin
                        err_d   = 2'b11;
                        state_d = DONE;
                    end else if (misal_w) begin
                        err_d   = 2'b01;
                        state_d = DONE;
                    end else begin
                        err_d   = 2'b00;
                        state_d = REQ;
                        maddr_d = addr_al_w;
                        be_d    = be_w;
                        wdata_d = wdata_sh_w;
                        we_d    = st_w;
                    end
                end
            end
            REQ: begin
                // A grant wins over a coincident flush: the access has left, only the result is dropped
                if (mem_io.mem_gnt) begin
                    kill_d  = alu_io.in_flush;
                    cnt_d   = '0;
                    state_d = store_q ? DONE : WAIT;
                end else if (alu_io.in_flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (alu_io.in_flush) kill_d = 1'b1;
                if (mem_io.mem_rvalid) begin
                    data_d  = ext_w;
                    state_d = (kill_q || alu_io.in_flush) ? IDLE : DONE;
                end else if (cnt_inc_w == CW'(TIMEOUT)) begin
                    err_d   = 2'b10;
                    state_d = (kill_q || alu_io.in_flush) ? IDLE : DONE;
                end else begin
                    cnt_d = cnt_inc_w;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= '0;
            maddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            err_q   <= err_d;
            maddr_q <= maddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign alu_io.in_ready  = (state_q == IDLE);
    assign alu_io.out_valid = (state_q == DONE) && !kill_q && !alu_io.in_flush;
    assign alu_io.out_wen   = alu_io.out_valid && !store_q && (err_q == 2'b00) && (rd_q != 5'd0);
    assign alu_io.out_rd    = rd_q;
    assign alu_io.out_data  = data_q;
    assign alu_io.out_err   = err_q;

    assign mem_io.mem_req   = (state_q == REQ);
    assign mem_io.mem_we    = we_q;
    assign mem_io.mem_addr  = maddr_q;
    assign mem_io.mem_be    = be_q;
    assign mem_io.mem_wdata = wdata_q;
endmodule

// File: doc/exe_lsu.md
# exe_lsu

Parametrised load/store unit that replaces the single-cycle data-cache path in the execute stage. It accepts one memory operation at a time from the ALU side over a valid/ready handshake and drives a variable-latency data-memory port with request/grant and response-valid signalling. It aligns byte/half/word(/double) data, sign- or zero-extends loads, flags misaligned accesses and bus timeouts, and supports a pipeline kill on branch mispredict.

## Interface
- XLEN, 32, data width; legal values 32 or 64.
- TIMEOUT, 255, max cycles from grant to rvalid before bus error; counter width is clog2(TIMEOUT+1).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit idle and able to accept.
- in_op  in  4  bit3 = store; bits2:0 = RISC-V funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- in_addr  in  XLEN  byte address (ALU result).
- in_wdata  in  XLEN  store data, LSB-aligned.
- in_rd  in  5  load destination register.
- in_flush  in  1  kill the in-flight operation (branch mispredict).
- mem_req  out  1  request valid; held until mem_gnt.
- mem_we  out  1  1 = write.
- mem_addr  out  XLEN  address with low clog2(XLEN/8) bits cleared.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  store data shifted to byte lane.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- out_valid  out  1  one-cycle completion pulse.
- out_wen  out  1  write out_data to out_rd (loads only, no error).
- out_rd  out  5  destination register.
- out_data  out  XLEN  extended load result.
- out_err  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal op.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. in_valid & !in_flush captures op/addr/wdata/rd. Legal aligned op -> REQ; misaligned, illegal (D/WU when XLEN=32, 111, or store with bit2 set) -> DONE with out_err set, no memory access.
- Alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
- REQ: mem_req=1, mem_addr/mem_we/mem_be/mem_wdata stable until mem_gnt. Store + gnt -> DONE. Load + gnt -> WAIT, timeout counter cleared.
- WAIT: counter increments each cycle; mem_rvalid -> DONE capturing lane-selected, extended data; counter reaching TIMEOUT -> DONE with out_err=10.
- DONE: out_valid=1 for exactly one cycle, then IDLE. out_wen=1 only for error-free loads; out_rd=0 forces out_wen=0.
- Extension: B/H/W sign-extend from bit 7/15/31; BU/HU/WU zero-extend.
- Flush: in IDLE, blocks acceptance that cycle. In REQ before gnt: mem_req drops next cycle, go IDLE, no out_valid. In REQ with gnt same cycle: treat as granted, then kill. In WAIT: set kill flag, keep waiting for rvalid/timeout, return to IDLE without out_valid. In DONE: out_valid suppressed.
- Store with flush coincident with gnt: write already issued; no out_valid.

## Timing
- Reset: state IDLE, in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, out_valid=0, out_wen=0, out_rd=0, out_data=0, out_err=0, counter 0, kill flag 0.
- Acceptance cycle T: mem_req high from T+1 (registered).
- Load, gnt at T+1, rvalid at T+2: out_valid at T+3. Minimum load latency 3 cycles, store 2 (gnt T+1, out_valid T+2), error 1 (out_valid T+1).
- Back-to-back: next op accepted the cycle after out_valid (in_ready high in IDLE only); throughput one op per 3 cycles minimum.
- rvalid outside WAIT ignored. rvalid and timeout in same cycle: rvalid wins.
- Reset mid-operation: immediate return to IDLE, mem_req dropped asynchronously.

## Test plan
- LB, addr 0x1003, rdata 0x80FF_0000 (XLEN=32), gnt T+1, rvalid T+2 -> out_valid T+3, out_data 0xFFFF_FF80, out_wen=1.
- SH, addr 0x2002, wdata 0x0000_ABCD, gnt delayed 3 cycles -> mem_req held 3 cycles, mem_be 1100, mem_wdata 0xABCD_0000, mem_addr 0x2000, out_valid 1 cycle after gnt, out_wen=0.
- LW addr 0x3001 -> no mem_req, out_valid T+1, out_err=01, out_wen=0.
- LHU with TIMEOUT=4, no rvalid -> out_valid exactly 5 cycles after gnt, out_err=10; late rvalid afterwards ignored.
- LW, in_flush in WAIT, rvalid 2 cycles later -> no out_valid, in_ready returns after rvalid, next LW completes normally.
- XLEN=64: LWU addr 0x4004, rdata 0xF000_0001_0000_0000 -> out_data 0x0000_0000_F000_0001; LD with XLEN=32 -> out_err=11.
